rdmem_copy: RTL and testbench

- Parametrised frame-copy engine: on `valid`, walks a frame of FRAME_LEN words in a source RAM and re-writes a selectable window of them into a destination RAM at an address offset.
- Sits between the word-capture RAM and the transmit/format RAM of the BCD frame path.
- Successor to the fixed 18-bit/96-word/window-2..94/offset+1 copier.
- Adds:
  - runtime window and offset
  - configurable read latency and write-strobe width
  - optional abort on `valid` drop
  - written-word counter and address-wrap flag

---
 rtl/rdmem_pkg.sv | 18 +
 rtl/rdmem_copy.sv | 167 ++++++++++++++++
 tb/tb_rdmem_copy.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rdmem_pkg.sv
// Shared definitions for the frame-copy engine: FSM state encoding and
// default geometry of the BCD frame path.
package rdmem_pkg;

    localparam int unsigned DW_DEF        = 18;
    localparam int unsigned AW_DEF        = 7;
    localparam int unsigned FRAME_LEN_DEF = 96;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        NEXT,
        WAIT_LOW
    } state_t;

endpackage

// File: rtl/rdmem_copy.sv
// Frame-copy engine: on valid, walks FRAME_LEN source words and rewrites the
// latched window [winLo..winHi] into the destination RAM at address + offset.
// Ports:
//   clk, nRST                 clock, async active-low reset
//   valid                     frame-ready level from upstream
//   iWinLo/iWinHi/iOffset     window bounds and write offset (latched at start)
//   iData                     source RAM read data
//   addrRD, rdVal             source read address / strobe
//   addrWR, oData, wrVal      destination write address / data / strobe
//   busy                      frame in progress
//   test                      frame done, held until valid low
//   oAbort                    one-cycle abort pulse
//   oWrap                     some write address wrapped in this frame
//   oWrCnt                    words written in current/last frame
module rdmem_copy
    import rdmem_pkg::*;
#(
    parameter int unsigned DW            = DW_DEF,
    parameter int unsigned AW            = AW_DEF,
    parameter int unsigned FRAME_LEN     = FRAME_LEN_DEF,
    parameter int unsigned RD_LAT        = 2,
    parameter int unsigned WR_HOLD       = 2,
    parameter bit          ABORT_ON_DROP = 1'b0
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          valid,
    input  logic [AW-1:0] iWinLo,
    input  logic [AW-1:0] iWinHi,
    input  logic [AW-1:0] iOffset,
    input  logic [DW-1:0] iData,
    output logic [AW-1:0] addrRD,
    output logic          rdVal,
    output logic [AW-1:0] addrWR,
    output logic [DW-1:0] oData,
    output logic          wrVal,
    output logic          busy,
    output logic          test,
    output logic          oAbort,
    output logic          oWrap,
    output logic [AW:0]   oWrCnt
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = $clog2(RD_LAT + 1);
    localparam int unsigned HW = $clog2(WR_HOLD + 1);

    localparam logic [AW-1:0] CNT_LAST  = AW'(FRAME_LEN - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(RD_LAT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(WR_HOLD - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [LW-1:0] lat;
    logic [HW-1:0] hold;
    logic [AW-1:0] win_lo, win_hi, win_off;
    logic [AW:0]   wr_sum;
    logic          in_win;
    logic          drop;

    // Carry bit of the unwrapped write address flags a wrap.
    assign wr_sum = {1'b0, cnt} + {1'b0, win_off};
    assign in_win = (cnt >= win_lo) && (cnt <= win_hi);
    assign drop   = ABORT_ON_DROP && !valid &&
                    (state inside {RD, RWAIT, WR, NEXT});

    // Copy FSM with registered outputs.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            lat     <= '0;
            hold    <= '0;
            win_lo  <= '0;
            win_hi  <= '0;
            win_off <= '0;
            addrRD  <= '0;
            rdVal   <= 1'b0;
            addrWR  <= '0;
            oData   <= '0;
            wrVal   <= 1'b0;
            busy    <= 1'b0;
            test    <= 1'b0;
            oAbort  <= 1'b0;
            oWrap   <= 1'b0;
            oWrCnt  <= '0;
        end else begin
            oAbort <= 1'b0;
            if (drop) begin
                rdVal  <= 1'b0;
                wrVal  <= 1'b0;
                busy   <= 1'b0;
                oAbort <= 1'b1;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        addrRD <= '0;
                        addrWR <= '0;
                        cnt    <= '0;
                        if (valid) begin
                            win_lo  <= iWinLo;
                            win_hi  <= iWinHi;
                            win_off <= iOffset;
                            oWrCnt  <= '0;
                            oWrap   <= 1'b0;
                            busy    <= 1'b1;
                            state   <= RD;
                        end
                    end
                    RD: begin
                        addrRD <= cnt;
                        rdVal  <= 1'b1;
                        lat    <= '0;
                        state  <= RWAIT;
                    end
                    // Data is captured straight into oData so the write strobe
                    // rises on the same edge the read strobe falls.
                    RWAIT: begin
                        if (lat == LAT_LAST) begin
                            rdVal <= 1'b0;
                            if (in_win) begin
                                addrWR <= wr_sum[AW-1:0];
                                oData  <= iData;
                                wrVal  <= 1'b1;
                                oWrCnt <= oWrCnt + CW'(1);
                                if (wr_sum[AW]) oWrap <= 1'b1;
                                hold   <= '0;
                                state  <= WR;
                            end else begin
                                state <= NEXT;
                            end
                        end else begin
                            lat <= lat + LW'(1);
                        end
                    end
                    WR: begin
                        if (hold == HOLD_LAST) begin
                            wrVal <= 1'b0;
                            state <= NEXT;
                        end else begin
                            hold <= hold + HW'(1);
                        end
                    end
                    NEXT: begin
                        if (cnt == CNT_LAST) begin
                            test  <= 1'b1;
                            busy  <= 1'b0;
                            state <= WAIT_LOW;
                        end else begin
                            cnt   <= cnt + AW'(1);
                            state <= RD;
                        end
                    end
                    WAIT_LOW: begin
                        if (!valid) begin
                            test  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rdmem_copy.sv
// Bench for rdmem_copy: default instance driven from a vector table, plus a
// RD_LAT=3 / WR_HOLD=1 / abort-enabled instance for multi-cycle corner cases.
module tb_rdmem_copy;

    logic clk;
    logic nRST;

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] src [128];

    // ---------------- instance 0: defaults ----------------
    logic        valid0;
    logic [6:0]  wl0, wh0, off0, ard0, awr0;
    logic [17:0] idata0, od0;
    logic        rdv0, wrv0, busy0, test0, abt0, wrap0;
    logic [7:0]  cnt0;

    rdmem_copy u0 (
        .clk(clk), .nRST(nRST), .valid(valid0),
        .iWinLo(wl0), .iWinHi(wh0), .iOffset(off0), .iData(idata0),
        .addrRD(ard0), .rdVal(rdv0), .addrWR(awr0), .oData(od0), .wrVal(wrv0),
        .busy(busy0), .test(test0), .oAbort(abt0), .oWrap(wrap0), .oWrCnt(cnt0)
    );

    assign idata0 = src[ard0];

    // ---------------- instance 1: RD_LAT=3, WR_HOLD=1, abort ----------------
    logic        valid1;
    logic [6:0]  wl1, wh1, off1, ard1, awr1;
    logic [17:0] idata1, od1, p1a, p1b;
    logic        rdv1, wrv1, busy1, test1, abt1, wrap1;
    logic [7:0]  cnt1;

    rdmem_copy #(.RD_LAT(3), .WR_HOLD(1), .ABORT_ON_DROP(1'b1)) u1 (
        .clk(clk), .nRST(nRST), .valid(valid1),
        .iWinLo(wl1), .iWinHi(wh1), .iOffset(off1), .iData(idata1),
        .addrRD(ard1), .rdVal(rdv1), .addrWR(awr1), .oData(od1), .wrVal(wrv1),
        .busy(busy1), .test(test1), .oAbort(abt1), .oWrap(wrap1), .oWrCnt(cnt1)
    );

    // Pipelined source RAM: data for an address appears two edges later.
    always @(posedge clk) begin
        p1a <= src[ard1];
        p1b <= p1a;
    end
    assign idata1 = p1b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitors ----------------
    int wa0[$], wd0[$], wa1[$], wd1[$], ra1[$];
    int rdb0, rdrun0, rdmin0, rdmax0, wrrun0, wrmin0, wrmax0, ovl0, herr0;
    int rdb1, rdrun1, rdmin1, rdmax1, wrrun1, wrmin1, wrmax1, ovl1;
    logic rdq0 = 1'b0, wrq0 = 1'b0, rdq1 = 1'b0, wrq1 = 1'b0;
    logic [6:0]  la0;
    logic [17:0] ld0;

    always @(negedge clk) begin
        if (rdv0 && wrv0) ovl0++;
        if (rdv0 && !rdq0) rdb0++;
        if (rdv0) rdrun0++;
        else if (rdq0) begin
            if (rdrun0 < rdmin0) rdmin0 = rdrun0;
            if (rdrun0 > rdmax0) rdmax0 = rdrun0;
            rdrun0 = 0;
        end
        if (wrv0) wrrun0++;
        else if (wrq0) begin
            if (wrrun0 < wrmin0) wrmin0 = wrrun0;
            if (wrrun0 > wrmax0) wrmax0 = wrrun0;
            wrrun0 = 0;
        end
        if (wrv0 && !wrq0) begin
            wa0.push_back(int'(awr0));
            wd0.push_back(int'(od0));
        end
        if (wrv0 && wrq0 && (awr0 != la0 || od0 != ld0)) herr0++;
        la0  = awr0;
        ld0  = od0;
        rdq0 = rdv0;
        wrq0 = wrv0;
    end

    always @(negedge clk) begin
        if (rdv1 && wrv1) ovl1++;
        if (rdv1 && !rdq1) begin
            rdb1++;
            ra1.push_back(int'(ard1));
        end
        if (rdv1) rdrun1++;
        else if (rdq1) begin
            if (rdrun1 < rdmin1) rdmin1 = rdrun1;
            if (rdrun1 > rdmax1) rdmax1 = rdrun1;
            rdrun1 = 0;
        end
        if (wrv1) wrrun1++;
        else if (wrq1) begin
            if (wrrun1 < wrmin1) wrmin1 = wrrun1;
            if (wrrun1 > wrmax1) wrmax1 = wrrun1;
            wrrun1 = 0;
        end
        if (wrv1 && !wrq1) begin
            wa1.push_back(int'(awr1));
            wd1.push_back(int'(od1));
        end
        rdq1 = rdv1;
        wrq1 = wrv1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr0();
        wa0.delete(); wd0.delete();
        rdb0 = 0; rdrun0 = 0; rdmin0 = 1000; rdmax0 = 0;
        wrrun0 = 0; wrmin0 = 1000; wrmax0 = 0; ovl0 = 0; herr0 = 0;
    endtask

    task automatic clr1();
        wa1.delete(); wd1.delete(); ra1.delete();
        rdb1 = 0; rdrun1 = 0; rdmin1 = 1000; rdmax1 = 0;
        wrrun1 = 0; wrmin1 = 1000; wrmax1 = 0; ovl1 = 0;
    endtask

    // Count of logged writes that disagree with src[idx] at (idx+off) mod 128.
    function automatic int bad_writes(input int q_a[$], input int q_d[$],
                                      input int lo, input int off);
        int bad = 0;
        for (int k = 0; k < q_a.size(); k++) begin
            if (q_a[k] != ((lo + k + off) % 128)) bad++;
            if (q_d[k] != (lo + k + 'h100)) bad++;
        end
        return bad;
    endfunction

    typedef struct {
        int lo, hi, off;
        int n, wrap;
        int fa, fd, la, ld;
        int glitch;
    } vec_t;

    vec_t vt[6];

    // Run one frame on instance 0 and check everything against the vector.
    task automatic run0(input vec_t v, input int id);
        int    cyc;
        string tg;
        tg = $sformatf("v%0d", id);
        clr0();
        @(negedge clk);
        wl0 = 7'(v.lo); wh0 = 7'(v.hi); off0 = 7'(v.off); valid0 = 1'b1;
        @(negedge clk);
        wl0 = 7'($urandom); wh0 = 7'($urandom); off0 = 7'($urandom);
        cyc = 0;
        while (!test0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (v.glitch != 0 && cyc == 100) valid0 = 1'b0;
            if (v.glitch != 0 && cyc == 103) valid0 = 1'b1;
        end
        check({tg, "_cycles"}, cyc, 96 * 4 + v.n * 2);
        check({tg, "_test"}, int'(test0), 1);
        check({tg, "_busy"}, int'(busy0), 0);
        check({tg, "_wrcnt"}, int'(cnt0), v.n);
        check({tg, "_wrap"}, int'(wrap0), v.wrap);
        check({tg, "_nwrites"}, wa0.size(), v.n);
        check({tg, "_writes_ok"}, bad_writes(wa0, wd0, v.lo, v.off), 0);
        check({tg, "_rdbursts"}, rdb0, 96);
        check({tg, "_rdw_min"}, rdmin0, 2);
        check({tg, "_rdw_max"}, rdmax0, 2);
        check({tg, "_overlap"}, ovl0, 0);
        check({tg, "_hold"}, herr0, 0);
        if (v.n != 0 && wa0.size() == v.n) begin
            check({tg, "_first_a"}, wa0[0], v.fa);
            check({tg, "_first_d"}, wd0[0], v.fd);
            check({tg, "_last_a"}, wa0[v.n-1], v.la);
            check({tg, "_last_d"}, wd0[v.n-1], v.ld);
            check({tg, "_wrw_min"}, wrmin0, 2);
            check({tg, "_wrw_max"}, wrmax0, 2);
        end
        valid0 = 1'b0;
        @(negedge clk);
        check({tg, "_test_low"}, int'(test0), 0);
        check({tg, "_cnt_kept"}, int'(cnt0), v.n);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        for (int i = 0; i < 128; i++) src[i] = 18'(i + 'h100);
        vt[0] = '{2,  94,  1,   93, 0, 3,   'h102, 95,  'h15E, 0};
        vt[1] = '{0,  95,  120, 96, 1, 120, 'h100, 87,  'h15F, 0};
        vt[2] = '{10, 5,   0,   0,  0, 0,   0,     0,   0,     0};
        vt[3] = '{0,  0,   127, 1,  0, 127, 'h100, 127, 'h100, 0};
        vt[4] = '{95, 127, 5,   1,  0, 100, 'h15F, 100, 'h15F, 0};
        vt[5] = '{2,  94,  1,   93, 0, 3,   'h102, 95,  'h15E, 1};

        nRST = 1'b0;
        valid0 = 1'b0; wl0 = '0; wh0 = '0; off0 = '0;
        valid1 = 1'b0; wl1 = '0; wh1 = '0; off1 = '0;
        clr0(); clr1();
        repeat (2) @(negedge clk);
        check("reset_u0_zero", int'(|{ard0, rdv0, awr0, od0, wrv0, busy0,
                                       test0, abt0, wrap0, cnt0}), 0);
        check("reset_u1_zero", int'(|{ard1, rdv1, awr1, od1, wrv1, busy1,
                                       test1, abt1, wrap1, cnt1}), 0);
        nRST = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run0(vt[i], i);

        // Instance 1: full frame through the pipelined source RAM.
        clr1();
        wl1 = 7'd2; wh1 = 7'd94; off1 = 7'd1; valid1 = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!test1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("lat3_cycles", cyc, 96 * 5 + 93);
        check("lat3_nwrites", wa1.size(), 93);
        check("lat3_writes_ok", bad_writes(wa1, wd1, 2, 1), 0);
        check("lat3_rdw_min", rdmin1, 3);
        check("lat3_rdw_max", rdmax1, 3);
        check("lat3_wrw_min", wrmin1, 1);
        check("lat3_wrw_max", wrmax1, 1);
        check("lat3_overlap", ovl1, 0);
        check("lat3_abort_quiet", int'(abt1), 0);
        valid1 = 1'b0;
        repeat (2) @(negedge clk);

        // Abort after word 20 is written.
        clr1();
        valid1 = 1'b1;
        cyc = 0;
        while (wa1.size() < 19 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached", wa1.size(), 19);
        valid1 = 1'b0;
        @(negedge clk);
        check("abort_pulse", int'(abt1), 1);
        check("abort_rdval", int'(rdv1), 0);
        check("abort_wrval", int'(wrv1), 0);
        check("abort_busy", int'(busy1), 0);
        check("abort_test", int'(test1), 0);
        check("abort_wrcnt", int'(cnt1), 19);
        check("abort_wrap", int'(wrap1), 0);
        @(negedge clk);
        check("abort_one_cycle", int'(abt1), 0);
        check("abort_no_more_wr", wa1.size(), 19);

        // Restart after abort begins again at word 0.
        clr1();
        valid1 = 1'b1;
        cyc = 0;
        while (!test1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("restart_first_rd", (ra1.size() > 0) ? ra1[0] : -1, 0);
        check("restart_nwrites", wa1.size(), 93);
        check("restart_wrcnt", int'(cnt1), 93);
        valid1 = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a write.
        clr1();
        valid1 = 1'b1;
        cyc = 0;
        while (!wrv1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_in_wr", int'(wrv1), 1);
        #2 nRST = 1'b0;
        #1;
        check("rst_async_u1", int'(|{ard1, rdv1, awr1, od1, wrv1, busy1,
                                      test1, abt1, wrap1, cnt1}), 0);
        valid1 = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        rdb1 = 0;
        repeat (5) @(negedge clk);
        check("rst_idle_busy", int'(busy1), 0);
        check("rst_idle_rd", rdb1, 0);
        check("rst_idle_abort", int'(abt1), 0);
        valid1 = 1'b1;
        @(negedge clk);
        check("rst_then_start", int'(busy1), 1);
        valid1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
